// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg
//   Shared constants for the button conditioning slice.
//   - Bit positions inside button_word / accel_word.
//   - Debounce state encoding (legacy one-bit RELEASED/PRESSED).
//   - Saturating add used by the steering magnitude ramp.
package button_conditioner_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned MAG_W  = 15;

  // button_word bit positions
  localparam int unsigned BTN_DOWN        = 0;
  localparam int unsigned BTN_UP          = 1;
  localparam int unsigned BTN_DOWN_STICKY = 2;
  localparam int unsigned BTN_UP_STICKY   = 3;

  // accel_word direction bit (1 = left); magnitude occupies the bits below
  localparam int unsigned ACCEL_DIR_BIT = 15;

  // debounce state encoding
  localparam logic [0:0] RELEASED = 1'b0;
  localparam logic [0:0] PRESSED  = 1'b1;

  // Widened add so a large step near the limit clamps instead of wrapping.
  function automatic logic [MAG_W-1:0] steer_sat_add(
    input logic [MAG_W-1:0] cur,
    input logic [MAG_W-1:0] step,
    input logic [MAG_W-1:0] limit
  );
    logic [MAG_W:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if (sum > {1'b0, limit}) begin
      return limit;
    end
    return sum[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if
//   CPU-facing bus of the button conditioner.
//   button_rd   : one-cycle strobe, CPU consumed button_word (clears sticky flags)
//   button_word : debounced up/down levels and sticky press flags
//   accel_word  : {direction, steering magnitude}
//   db_level    : debounced levels {up,down,left,right}, 1 = pressed
//   master = CPU side, slave = conditioner side.
interface button_conditioner_if;
  import button_conditioner_pkg::*;

  logic              button_rd;
  logic [WORD_W-1:0] button_word;
  logic [WORD_W-1:0] accel_word;
  logic [3:0]        db_level;

  modport master (
    output button_rd,
    input  button_word,
    input  accel_word,
    input  db_level
  );

  modport slave (
    input  button_rd,
    output button_word,
    output accel_word,
    output db_level
  );

endinterface

// File: rtl/button_conditioner_debounce_fsm.sv
// button_conditioner_debounce_fsm
//   One raw active-low button: inversion, 2-flop synchronizer and a
//   RELEASED/PRESSED debounce FSM. A level change is accepted only after
//   DEBOUNCE_CYCLES consecutive synchronized samples disagree with the
//   current level; any agreeing sample restarts the count.
//   clock  : system clock
//   reset  : asynchronous, active-high
//   raw_n  : raw button, active low, asynchronous to clock
//   db     : debounced level, 1 = pressed
//   rise   : one-cycle pulse, coincident with the first cycle db reads pressed
module button_conditioner_debounce_fsm
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_n,
  output logic db,
  output logic rise
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_s;
  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;

  assign db = (state == PRESSED);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_s    <= 1'b0;
      state     <= RELEASED;
      cnt       <= '0;
      rise      <= 1'b0;
    end else begin
      sync_meta <= ~raw_n;
      sync_s    <= sync_meta;
      rise      <= 1'b0;
      if (sync_s == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        state <= (state == PRESSED) ? RELEASED : PRESSED;
        rise  <= (state == RELEASED);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner
//   Conditions the four raw active-low board buttons into two registered
//   16-bit words for the datapath:
//     button_word : [1]=up level, [0]=down level, [3]=up sticky press,
//                   [2]=down sticky press, [15:4]=0. Sticky flags clear
//                   when the CPU strobes button_rd.
//     accel_word  : [15]=direction (1=left), [14:0]=steering magnitude that
//                   starts at STEER_STEP and ramps by STEER_STEP every
//                   RAMP_DIV cycles up to STEER_MAX while one steer button
//                   is held alone.
//   Ports:
//     clock, reset (async, active-high)
//     up/down/left/right_button_n : raw buttons, active low
//     bus (slave) : button_rd in; button_word, accel_word, db_level out
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned       DEBOUNCE_CYCLES = 500000,
  parameter int unsigned       RAMP_DIV        = 250000,
  parameter logic [MAG_W-1:0]  STEER_STEP      = 15'd256,
  parameter logic [MAG_W-1:0]  STEER_MAX       = 15'd16383
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  up_button_n,
  input  logic                  down_button_n,
  input  logic                  left_button_n,
  input  logic                  right_button_n,
  button_conditioner_if.slave   bus
);

  localparam int unsigned       RCNT_W    = $clog2(RAMP_DIV + 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RAMP_DIV - 1);

  logic db_up, db_down, db_left, db_right;
  logic rise_up, rise_down, rise_left, rise_right;

  button_conditioner_debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clock (clock),
    .reset (reset),
    .raw_n (up_button_n),
    .db    (db_up),
    .rise  (rise_up)
  );

  button_conditioner_debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clock (clock),
    .reset (reset),
    .raw_n (down_button_n),
    .db    (db_down),
    .rise  (rise_down)
  );

  button_conditioner_debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clock (clock),
    .reset (reset),
    .raw_n (left_button_n),
    .db    (db_left),
    .rise  (rise_left)
  );

  button_conditioner_debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clock (clock),
    .reset (reset),
    .raw_n (right_button_n),
    .db    (db_right),
    .rise  (rise_right)
  );

  assign bus.db_level = {db_up, db_down, db_left, db_right};

  // ---------------------------------------------------------------------
  // Button word: registered levels plus sticky press flags
  // ---------------------------------------------------------------------
  logic up_lvl_q, down_lvl_q;
  logic up_flag_q, down_flag_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      up_lvl_q    <= 1'b0;
      down_lvl_q  <= 1'b0;
      up_flag_q   <= 1'b0;
      down_flag_q <= 1'b0;
    end else begin
      up_lvl_q    <= db_up;
      down_lvl_q  <= db_down;
      // a press landing on the same cycle as the read survives the clear
      up_flag_q   <= rise_up   | (up_flag_q   & ~bus.button_rd);
      down_flag_q <= rise_down | (down_flag_q & ~bus.button_rd);
    end
  end

  always_comb begin
    bus.button_word                  = '0;
    bus.button_word[BTN_UP]          = up_lvl_q;
    bus.button_word[BTN_DOWN]        = down_lvl_q;
    bus.button_word[BTN_UP_STICKY]   = up_flag_q;
    bus.button_word[BTN_DOWN_STICKY] = down_flag_q;
  end

  // ---------------------------------------------------------------------
  // Steering ramp
  // ---------------------------------------------------------------------
  logic              steer_dir_q;
  logic [MAG_W-1:0]  steer_mag_q;
  logic [RCNT_W-1:0] rcnt_q;
  logic              steer_active_q;
  logic              steer_one;
  logic              steer_start;

  // A single-button hold starts fresh when nothing was steering last cycle
  // (from idle, or one of a both-held pair released), or when the button now
  // held just rose while steering was active: with one button held alone the
  // only way for it to rise is a direction change, including a same-edge
  // swap of left and right.
  always_comb begin
    steer_one   = db_left ^ db_right;
    steer_start = !steer_active_q || (db_left ? rise_left : rise_right);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      steer_dir_q    <= 1'b0;
      steer_mag_q    <= '0;
      rcnt_q         <= '0;
      steer_active_q <= 1'b0;
    end else if (steer_one) begin
      steer_active_q <= 1'b1;
      if (steer_start) begin
        steer_mag_q <= STEER_STEP;
        steer_dir_q <= db_left;
        rcnt_q      <= '0;
      end else if (rcnt_q == RCNT_LAST) begin
        rcnt_q      <= '0;
        steer_mag_q <= steer_sat_add(steer_mag_q, STEER_STEP, STEER_MAX);
      end else begin
        rcnt_q <= rcnt_q + 1'b1;
      end
    end else begin
      steer_dir_q    <= 1'b0;
      steer_mag_q    <= '0;
      rcnt_q         <= '0;
      steer_active_q <= 1'b0;
    end
  end

  always_comb begin
    bus.accel_word                  = '0;
    bus.accel_word[ACCEL_DIR_BIT]   = steer_dir_q;
    bus.accel_word[MAG_W-1:0]       = steer_mag_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
//   Directed bench for button_conditioner with DEBOUNCE_CYCLES=4,
//   RAMP_DIV=3, STEER_STEP=1, STEER_MAX=5. Reset behaviour is a hand-written
//   sequence; the rest is a table of {inputs, edges to advance, expected
//   outputs} records. Inputs are driven and outputs sampled 1 time unit
//   after a rising edge.
module tb_button_conditioner;
  import button_conditioner_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic up_n, down_n, left_n, right_n;

  button_conditioner_if bus();

  button_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .RAMP_DIV        (3),
    .STEER_STEP      (15'd1),
    .STEER_MAX       (15'd5)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .up_button_n    (up_n),
    .down_button_n  (down_n),
    .left_button_n  (left_n),
    .right_button_n (right_n),
    .bus            (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // in = {up_n, down_n, left_n, right_n, button_rd}
  typedef struct {
    logic [4:0]  in;
    int          n;
    logic [15:0] bw;
    logic [15:0] aw;
    logic [3:0]  db;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [4:0] in, input int n, input logic [15:0] bw,
                     input logic [15:0] aw, input logic [3:0] db);
    vec_t v;
    v.in = in;
    v.n  = n;
    v.bw = bw;
    v.aw = aw;
    v.db = db;
    vt.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    // ---------------- reset and reset-while-held ----------------
    reset          = 1'b1;
    up_n           = 1'b1;
    down_n         = 1'b1;
    left_n         = 1'b1;
    right_n        = 1'b1;
    bus.button_rd  = 1'b0;
    #2;
    check("reset.bw", bus.button_word, 16'h0000);
    check("reset.aw", bus.accel_word, 16'h0000);
    check("reset.db", {12'h000, bus.db_level}, 16'h0000);
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b0;

    up_n   = 1'b0;
    left_n = 1'b0;
    step(10);
    check("pre_rst.bw", bus.button_word, 16'h000A);
    check("pre_rst.aw", bus.accel_word, 16'h8002);
    check("pre_rst.db", {12'h000, bus.db_level}, 16'h000A);

    #3 reset = 1'b1;
    #1;
    check("async_rst.bw", bus.button_word, 16'h0000);
    check("async_rst.aw", bus.accel_word, 16'h0000);
    check("async_rst.db", {12'h000, bus.db_level}, 16'h0000);
    left_n = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    step(6);
    check("post_rst6.bw", bus.button_word, 16'h0000);
    check("post_rst6.db", {12'h000, bus.db_level}, 16'h0008);
    step(1);
    check("post_rst7.bw", bus.button_word, 16'h000A);
    check("post_rst7.aw", bus.accel_word, 16'h0000);

    up_n = 1'b1;
    step(7);
    check("rel_up.bw", bus.button_word, 16'h0008);
    bus.button_rd = 1'b1;
    step(1);
    bus.button_rd = 1'b0;
    check("rd_clear.bw", bus.button_word, 16'h0000);

    // ---------------- table ----------------
    // bounce on up, then a clean hold
    add(5'b01110, 3, 16'h0000, 16'h0000, 4'b0000);
    add(5'b11110, 1, 16'h0000, 16'h0000, 4'b0000);
    add(5'b01110, 3, 16'h0000, 16'h0000, 4'b0000);
    add(5'b11110, 1, 16'h0000, 16'h0000, 4'b0000);
    add(5'b01110, 6, 16'h0000, 16'h0000, 4'b1000);
    add(5'b01110, 1, 16'h000A, 16'h0000, 4'b1000);
    // sticky flag survives release, read clears it
    add(5'b11110, 6, 16'h000A, 16'h0000, 4'b0000);
    add(5'b11110, 1, 16'h0008, 16'h0000, 4'b0000);
    add(5'b11111, 1, 16'h0000, 16'h0000, 4'b0000);
    // read coinciding with a new down rise
    add(5'b01110, 7, 16'h000A, 16'h0000, 4'b1000);
    add(5'b00110, 6, 16'h000A, 16'h0000, 4'b1100);
    add(5'b00111, 1, 16'h0007, 16'h0000, 4'b1100);
    add(5'b11111, 1, 16'h0003, 16'h0000, 4'b1100);
    add(5'b11110, 5, 16'h0003, 16'h0000, 4'b0000);
    add(5'b11110, 1, 16'h0000, 16'h0000, 4'b0000);
    // left held: ramp and saturate
    add(5'b11010, 6, 16'h0000, 16'h0000, 4'b0010);
    add(5'b11010, 1, 16'h0000, 16'h8001, 4'b0010);
    add(5'b11010, 2, 16'h0000, 16'h8001, 4'b0010);
    add(5'b11010, 1, 16'h0000, 16'h8002, 4'b0010);
    add(5'b11010, 3, 16'h0000, 16'h8003, 4'b0010);
    add(5'b11010, 3, 16'h0000, 16'h8004, 4'b0010);
    add(5'b11010, 3, 16'h0000, 16'h8005, 4'b0010);
    add(5'b11010, 3, 16'h0000, 16'h8005, 4'b0010);
    add(5'b11010, 3, 16'h0000, 16'h8005, 4'b0010);
    add(5'b11110, 6, 16'h0000, 16'h8005, 4'b0000);
    add(5'b11110, 1, 16'h0000, 16'h0000, 4'b0000);
    // both held, then left released
    add(5'b11000, 7, 16'h0000, 16'h0000, 4'b0011);
    add(5'b11100, 6, 16'h0000, 16'h0000, 4'b0001);
    add(5'b11100, 1, 16'h0000, 16'h0001, 4'b0001);
    add(5'b11100, 3, 16'h0000, 16'h0002, 4'b0001);
    // right -> left swap on the same debounced edge
    add(5'b11010, 6, 16'h0000, 16'h0004, 4'b0010);
    add(5'b11010, 1, 16'h0000, 16'h8001, 4'b0010);
    add(5'b11010, 2, 16'h0000, 16'h8001, 4'b0010);
    add(5'b11010, 1, 16'h0000, 16'h8002, 4'b0010);
    add(5'b11110, 7, 16'h0000, 16'h0000, 4'b0000);

    for (int i = 0; i < vt.size(); i++) begin
      up_n          = vt[i].in[4];
      down_n        = vt[i].in[3];
      left_n        = vt[i].in[2];
      right_n       = vt[i].in[1];
      bus.button_rd = vt[i].in[0];
      step(vt[i].n);
      check($sformatf("v%0d.bw", i), bus.button_word, vt[i].bw);
      check($sformatf("v%0d.aw", i), bus.accel_word, vt[i].aw);
      check($sformatf("v%0d.db", i), {12'h000, bus.db_level}, {12'h000, vt[i].db});
    end
    bus.button_rd = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Input-conditioning stage directly upstream of the datapath's button_in/accel_in muxes. Takes the four raw active-low board buttons and produces two 16-bit words: a debounced button word with sticky press flags the CPU clears by reading, and a signed-magnitude steering word whose magnitude ramps while a steer button is held. It replaces the raw inversion/replication glue at top level.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable synchronized cycles required to accept a level change (10 ms at 50 MHz)
RAMP_DIV, 250000, cycles between steering magnitude increments
STEER_STEP, 15'd256, magnitude increment per ramp tick
STEER_MAX, 15'd16383, saturation value of the steering magnitude

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
up_button_n  in  1  raw button, active low, asynchronous to clock
down_button_n  in  1  raw button, active low
left_button_n  in  1  raw button, active low
right_button_n  in  1  raw button, active low
button_rd  in  1  one-cycle strobe: CPU consumed button_word; clears sticky flags
button_word  out  16  [1]=up level, [0]=down level, [3]=up sticky press, [2]=down sticky press, [15:4]=0
accel_word  out  16  [15]=direction (1=left), [14:0]=steering magnitude
db_level  out  4  debounced levels {up,down,left,right}, 1=pressed (debug/LEDs)

Behaviour:
- Reset (async, active-high): all sync flops, counters, and states cleared. button_word=0, accel_word=0, db_level=0 (every button reads released).
- Sync: each raw input is inverted, then passes through a 2-flop synchronizer. The result is s.
- Debounce, per button. States are RELEASED and PRESSED; db is the current level.
  - Counter cnt has width clog2(DEBOUNCE_CYCLES+1).
  - If s==db: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: toggle state and db, cnt<=0.
  - Else: cnt<=cnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored; cnt restarts on every bounce.
  - Latency: db changes on edge 2+DEBOUNCE_CYCLES after the raw change (raw held stable). button_word and accel_word are registered and follow one edge later (DEBOUNCE_CYCLES+3).
- Press event: a RELEASED->PRESSED transition of up/down pulses rise for one cycle.
- Sticky flags: flag<=rise | (flag & ~button_rd).
  - rise and button_rd in the same cycle: flag ends set (the new press is not lost).
  - Level bits [1:0] are not affected by button_rd.
- Steering: L and R are the debounced left/right levels.
  - Exactly one held, first cycle of this hold (or direction just changed): mag<=STEER_STEP, dir<=L, rcnt<=0.
  - Exactly one held, continuing: rcnt counts 0..RAMP_DIV-1. At wrap, mag<=min(mag+STEER_STEP, STEER_MAX). Compute in 16 bits before saturating, with no overflow wrap.
  - Neither or both held: mag<=0, dir<=0, rcnt<=0.
  - accel_word={dir, mag}, registered.
  - Simultaneous left release and right press (same edge): treated as a direction change; mag restarts at STEER_STEP.
- Reset mid-debounce or mid-ramp returns everything to reset values immediately. Buttons still held after reset release re-debounce from RELEASED and must produce a fresh rise.
- No combinational path from any input to any output.

Decomposition:
- Shared package: button bit-index constants (BTN_UP=1, BTN_DOWN=0, BTN_UP_STICKY=3, BTN_DOWN_STICKY=2, ACCEL_DIR_BIT=15), debounce state encoding (RELEASED=1'b0, PRESSED=1'b1).
- Sub-module debounce_fsm: one synchronizer plus debounce FSM with outputs db and rise, parameter DEBOUNCE_CYCLES. Instantiated four times. Steering ramp and sticky logic stay in the parent.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, RAMP_DIV=3, STEER_STEP=1, STEER_MAX=5.
1. Reset asserted mid-run with up held -> all outputs 0 asynchronously. After release, button_word[1] rises exactly 7 edges after reset deasserts; sticky [3] sets.
2. up_button_n low for 3 cycles, high 1, low 3 (bounce) -> button_word stays 0. Then held low 10 cycles -> button_word=16'h000A at edge 7 after the last transition.
3. Sticky set (button_word=16'h0008 after release). button_rd pulsed -> 16'h0000 next edge. Repeat with button_rd coinciding with a new down rise -> [2] set, [3] cleared.
4. left held 20 cycles -> accel_word goes 16'h8001, then +1 every 3 cycles to 16'h8005, holds at 16'h8005. Release -> 16'h0000 after debounce latency.
5. Both left and right held -> accel_word=0. Release left (right still held) -> 16'h0001, then ramps.
6. right->left swap on the same debounced edge -> accel_word jumps from {0,mag} to 16'h8001, with ramp counter restarted (next step exactly 3 cycles later).
